// File: rtl/hazard_ctrl_unit_pkg.sv
// rtl/hazard_ctrl_unit_pkg.sv - shared types and limits for the pipeline hazard controller
package hazard_ctrl_unit_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MC_WAIT = 1'b1
  } mc_state_t;

  localparam int FCNT_W    = 3;
  localparam int NBYP_MAX  = 4;
  localparam int FLUSH_MAX = 7;

endpackage

// File: rtl/hazard_wr_tracker.sv
// rtl/hazard_wr_tracker.sv - shift register of in-flight RF writes, one entry per bypass stage
module hazard_wr_tracker
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int AW   = 4,
  parameter int NBYP = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_valid,
  input  logic [AW-1:0]      push_addr,
  input  logic               push_load,
  output logic [NBYP-1:0]    ent_valid,
  output logic [NBYP*AW-1:0] ent_addr,
  output logic               ent0_load
);

  // Only the youngest entry can create a load-use hazard, so the load flag is not carried further.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_addr  <= '0;
      ent0_load <= 1'b0;
    end else begin
      ent_valid[0]      <= push_valid;
      ent_addr[AW-1:0]  <= push_addr;
      ent0_load         <= push_valid & push_load;
      for (int k = 1; k < NBYP; k++) begin
        ent_valid[k]          <= ent_valid[k-1];
        ent_addr[k*AW +: AW]  <= ent_addr[(k-1)*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - ID-stage hazard control: bypass selects, load-use, multi-cycle hold, flush, halt
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int AW        = 4,
  parameter int NRD       = 2,
  parameter int NBYP      = 2,
  parameter int FLUSH_CYC = 2,
  parameter int MC_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NRD-1:0]       id_rd_en,
  input  logic [NRD*AW-1:0]    id_rd_addr,
  input  logic                 id_wr_en,
  input  logic [AW-1:0]        id_wr_addr,
  input  logic                 id_is_load,
  input  logic [MC_W-1:0]      id_mc_cyc,
  input  logic                 id_hlt,
  input  logic                 flow_change,
  output logic                 stall_if,
  output logic                 bubble_ex,
  output logic                 flush,
  output logic [NRD*NBYP-1:0]  byp_sel,
  output logic                 mc_busy,
  output logic                 hlt_wb
);

  if (NBYP < 1 || NBYP > NBYP_MAX) begin : g_bad_nbyp
    $error("hazard_ctrl_unit: NBYP out of range");
  end
  if (FLUSH_CYC < 1 || FLUSH_CYC > FLUSH_MAX) begin : g_bad_flush
    $error("hazard_ctrl_unit: FLUSH_CYC out of range");
  end

  logic [NBYP-1:0]     ent_valid;
  logic [NBYP*AW-1:0]  ent_addr;
  logic                ent0_load;
  mc_state_t           state;
  logic [MC_W-1:0]     mcnt;
  logic [FCNT_W-1:0]   fcnt;
  logic                hlt_st;
  logic [NBYP:0]       hlt_pipe;
  logic                lu_raw, lu, mc_stall, accept, seen;
  logic [NRD*NBYP-1:0] byp_nxt;

  hazard_wr_tracker #(.AW(AW), .NBYP(NBYP)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .push_valid (accept & id_wr_en & (|id_wr_addr)),
    .push_addr  (id_wr_addr),
    .push_load  (id_is_load),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr),
    .ent0_load  (ent0_load)
  );

  always_comb begin
    lu_raw = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      if (id_rd_en[p] && ent_valid[0] && ent0_load &&
          id_rd_addr[p*AW +: AW] == ent_addr[AW-1:0])
        lu_raw = 1'b1;
    end
  end

  // Youngest matching stage wins, giving a one-hot or zero select per port.
  always_comb begin
    byp_nxt = '0;
    seen    = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      seen = 1'b0;
      for (int k = 0; k < NBYP; k++) begin
        if (id_rd_en[p] && (|id_rd_addr[p*AW +: AW]) && ent_valid[k] &&
            ent_addr[k*AW +: AW] == id_rd_addr[p*AW +: AW]) begin
          byp_nxt[p*NBYP+k] = !seen;
          seen = 1'b1;
        end
      end
    end
  end

  assign flush     = flow_change | (fcnt != '0);
  assign lu        = lu_raw & !flush;
  assign mc_stall  = !flush &
                     ((state == ST_IDLE && id_valid && id_mc_cyc != '0 && !lu_raw) ||
                      (state == ST_MC_WAIT && mcnt != '0));
  assign stall_if  = hlt_st | lu | mc_stall;
  assign bubble_ex = lu | mc_stall | flush;
  assign accept    = id_valid & !stall_if & !bubble_ex & !flush;
  assign hlt_wb    = hlt_pipe[NBYP];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mcnt    <= '0;
      mc_busy <= 1'b0;
    end else if (flush) begin
      state   <= ST_IDLE;
      mcnt    <= '0;
      mc_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (id_valid && id_mc_cyc != '0 && !lu_raw) begin
            state   <= ST_MC_WAIT;
            mcnt    <= id_mc_cyc - MC_W'(1);
            mc_busy <= (id_mc_cyc != MC_W'(1));
          end else begin
            mc_busy <= 1'b0;
          end
        end
        ST_MC_WAIT: begin
          if (mcnt != '0) begin
            mcnt    <= mcnt - MC_W'(1);
            mc_busy <= (mcnt != MC_W'(1));
          end else begin
            state   <= ST_IDLE;
            mc_busy <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mc_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt     <= '0;
      hlt_st   <= 1'b0;
      hlt_pipe <= '0;
      byp_sel  <= '0;
    end else begin
      if (flow_change)
        fcnt <= FCNT_W'(FLUSH_CYC - 1);
      else if (fcnt != '0)
        fcnt <= fcnt - FCNT_W'(1);
      hlt_st   <= hlt_st | (accept & id_hlt);
      hlt_pipe <= {hlt_pipe[NBYP-1:0], hlt_st};
      byp_sel  <= byp_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed-vector bench for hazard_ctrl_unit (AW=4, NRD=2, NBYP=2, FLUSH_CYC=2)
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_rd_en;
  logic [7:0] id_rd_addr;
  logic       id_wr_en;
  logic [3:0] id_wr_addr;
  logic       id_is_load;
  logic [2:0] id_mc_cyc;
  logic       id_hlt;
  logic       flow_change;
  logic       stall_if, bubble_ex, flush, mc_busy, hlt_wb;
  logic [3:0] byp_sel;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.AW(4), .NRD(2), .NBYP(2), .FLUSH_CYC(2), .MC_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rd_en    (id_rd_en),
    .id_rd_addr  (id_rd_addr),
    .id_wr_en    (id_wr_en),
    .id_wr_addr  (id_wr_addr),
    .id_is_load  (id_is_load),
    .id_mc_cyc   (id_mc_cyc),
    .id_hlt      (id_hlt),
    .flow_change (flow_change),
    .stall_if    (stall_if),
    .bubble_ex   (bubble_ex),
    .flush       (flush),
    .byp_sel     (byp_sel),
    .mc_busy     (mc_busy),
    .hlt_wb      (hlt_wb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] re, input logic [3:0] a0,
                       input logic [3:0] a1, input logic we, input logic [3:0] wa,
                       input logic ld, input logic [2:0] mc, input logic h, input logic fc);
    id_valid    = v;
    id_rd_en    = re;
    id_rd_addr  = {a1, a0};
    id_wr_en    = we;
    id_wr_addr  = wa;
    id_is_load  = ld;
    id_mc_cyc   = mc;
    id_hlt      = h;
    flow_change = fc;
    #2;
  endtask

  task automatic idle(input int n);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    vecs++; if (byp_sel !== 4'b0000) begin errs++; $display("FAIL reset_byp: got %b want 0000", byp_sel); end
    vecs++; if ({stall_if, bubble_ex, flush, mc_busy, hlt_wb} !== 5'b0) begin errs++;
      $display("FAIL reset_outs: got %b want 00000", {stall_if, bubble_ex, flush, mc_busy, hlt_wb}); end
    rst = 1'b0;
    idle(2);
    // ADD R1, then an MC op reading R1 enters MC_WAIT with a live bypass select
    drive(1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 2'b01, 1, 0, 0, 0, 0, 3, 0, 0); tick();
    vecs++; if (mc_busy !== 1'b1 || byp_sel !== 4'b0001) begin errs++;
      $display("FAIL reset_setup: got busy=%b byp=%b want busy=1 byp=0001", mc_busy, byp_sel); end
    rst = 1'b1; tick();
    vecs++; if (byp_sel !== 4'b0000 || mc_busy !== 1'b0 || hlt_wb !== 1'b0) begin errs++;
      $display("FAIL reset_mid_mc: got byp=%b busy=%b hlt=%b want 0000/0/0", byp_sel, mc_busy, hlt_wb); end
    rst = 1'b0;
    drive(1, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (stall_if !== 1'b0 || bubble_ex !== 1'b0) begin errs++;
      $display("FAIL reset_fsm_idle: got stall=%b bubble=%b want 0/0", stall_if, bubble_ex); end
    tick();
    vecs++; if (byp_sel !== 4'b0000) begin errs++; $display("FAIL reset_tracker: got %b want 0000", byp_sel); end
  endtask

  task automatic test_load_use;
    idle(2);
    drive(1, 2'b00, 0, 0, 1, 3, 1, 0, 0, 0);
    vecs++; if (stall_if !== 1'b0) begin errs++; $display("FAIL lu_lw_issue: got %b want 0", stall_if); end
    tick();
    drive(1, 2'b11, 3, 5, 1, 4, 0, 0, 0, 0);
    vecs++; if (stall_if !== 1'b1 || bubble_ex !== 1'b1 || flush !== 1'b0) begin errs++;
      $display("FAIL lu_stall: got stall=%b bubble=%b flush=%b want 1/1/0", stall_if, bubble_ex, flush); end
    tick();
    vecs++; if (byp_sel !== 4'b0001) begin errs++; $display("FAIL lu_byp_stallcyc: got %b want 0001", byp_sel); end
    vecs++; if (stall_if !== 1'b0 || bubble_ex !== 1'b0) begin errs++;
      $display("FAIL lu_one_cycle: got stall=%b bubble=%b want 0/0", stall_if, bubble_ex); end
    tick();
    vecs++; if (byp_sel !== 4'b0010) begin errs++; $display("FAIL lu_byp_dm: got %b want 0010", byp_sel); end
  endtask

  task automatic test_forward;
    idle(2);
    drive(1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 2'b11, 1, 1, 1, 2, 0, 0, 0, 0);
    vecs++; if (stall_if !== 1'b0) begin errs++; $display("FAIL fwd_no_stall: got %b want 0", stall_if); end
    tick();
    vecs++; if (byp_sel !== 4'b0101) begin errs++; $display("FAIL fwd_ex_both: got %b want 0101", byp_sel); end
    idle(2);
    drive(1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 2'b11, 0, 0, 1, 2, 0, 0, 0, 0); tick();
    vecs++; if (byp_sel !== 4'b0000) begin errs++; $display("FAIL fwd_r0: got %b want 0000", byp_sel); end
    idle(2);
    drive(1, 2'b00, 0, 0, 1, 6, 0, 0, 0, 0); tick();
    drive(1, 2'b00, 0, 0, 1, 6, 0, 0, 0, 0); tick();
    drive(1, 2'b10, 0, 6, 0, 0, 0, 0, 0, 0); tick();
    vecs++; if (byp_sel !== 4'b0100) begin errs++; $display("FAIL fwd_youngest: got %b want 0100", byp_sel); end
  endtask

  task automatic test_multicycle;
    logic exp_stall, exp_busy;
    idle(2);
    drive(1, 2'b00, 0, 0, 1, 6, 0, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      exp_stall = (i < 3);
      exp_busy  = (i < 2);
      #1;
      vecs++; if (stall_if !== exp_stall || bubble_ex !== exp_stall) begin errs++;
        $display("FAIL mc_stall_c%0d: got stall=%b bubble=%b want %b", i, stall_if, bubble_ex, exp_stall); end
      tick();
      vecs++; if (mc_busy !== exp_busy) begin errs++;
        $display("FAIL mc_busy_c%0d: got %b want %b", i, mc_busy, exp_busy); end
    end
    drive(1, 2'b01, 6, 0, 0, 0, 0, 0, 0, 0); tick();
    vecs++; if (byp_sel !== 4'b0001) begin errs++; $display("FAIL mc_issued: got %b want 0001", byp_sel); end
  endtask

  task automatic test_flush;
    idle(2);
    drive(1, 2'b00, 0, 0, 1, 7, 0, 5, 0, 0); tick();
    vecs++; if (mc_busy !== 1'b1) begin errs++; $display("FAIL fl_mc_enter: got %b want 1", mc_busy); end
    drive(1, 2'b00, 0, 0, 1, 7, 0, 5, 0, 1);
    vecs++; if (flush !== 1'b1 || bubble_ex !== 1'b1 || stall_if !== 1'b0) begin errs++;
      $display("FAIL fl_c0: got flush=%b bubble=%b stall=%b want 1/1/0", flush, bubble_ex, stall_if); end
    tick();
    vecs++; if (mc_busy !== 1'b0) begin errs++; $display("FAIL fl_mc_idle: got %b want 0", mc_busy); end
    drive(1, 2'b00, 0, 0, 1, 7, 0, 0, 0, 0);
    vecs++; if (flush !== 1'b1 || bubble_ex !== 1'b1) begin errs++;
      $display("FAIL fl_c1: got flush=%b bubble=%b want 1/1", flush, bubble_ex); end
    tick();
    drive(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (flush !== 1'b0 || stall_if !== 1'b0) begin errs++;
      $display("FAIL fl_end: got flush=%b stall=%b want 0/0", flush, stall_if); end
    tick();
    vecs++; if (byp_sel !== 4'b0000) begin errs++; $display("FAIL fl_no_entries: got %b want 0000", byp_sel); end
  endtask

  task automatic test_halt;
    idle(2);
    drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (stall_if !== 1'b0) begin errs++; $display("FAIL hlt_in_flush: got %b want 0", stall_if); end
    idle(4);
    vecs++; if (hlt_wb !== 1'b0) begin errs++; $display("FAIL hlt_in_flush_wb: got %b want 0", hlt_wb); end
    drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs++; if (stall_if !== 1'b0) begin errs++; $display("FAIL hlt_pre: got %b want 0", stall_if); end
    tick();
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs++; if (stall_if !== 1'b1) begin errs++; $display("FAIL hlt_sticky: got %b want 1", stall_if); end
    for (int j = 1; j <= 4; j++) begin
      tick();
      vecs++; if (hlt_wb !== (j >= 3)) begin errs++;
        $display("FAIL hlt_wb_c%0d: got %b want %b", j, hlt_wb, (j >= 3)); end
    end
    vecs++; if (stall_if !== 1'b1) begin errs++; $display("FAIL hlt_hold: got %b want 1", stall_if); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_multicycle();
    test_flush();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
